// File: rtl/seg_display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display blocks.
// Segment patterns are active-low; digit enables are active-high one-hot.
package seg_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_OPEN   = 2'd2,
        ST_SWITCH = 2'd3
    } arb_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    localparam logic [3:0] AN_OFF   = 4'b0000;
    localparam logic [3:0] AN_THOU  = 4'b0001;
    localparam logic [3:0] AN_HUND  = 4'b0010;
    localparam logic [3:0] AN_TENS  = 4'b0100;
    localparam logic [3:0] AN_UNITS = 4'b1000;

    function automatic logic [3:0] digit_onehot(input logic [1:0] idx);
        logic [3:0] an_v;
        case (idx)
            2'd0:    an_v = AN_THOU;
            2'd1:    an_v = AN_HUND;
            2'd2:    an_v = AN_TENS;
            2'd3:    an_v = AN_UNITS;
            default: an_v = AN_OFF;
        endcase
        return an_v;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD nibble to active-low 7-segment pattern (seg[6]=a .. seg[0]=g).
// Non-decimal nibbles render as a dash.
module bcd_to_seg7
    import seg_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Pure lookup, no state.
    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = 7'b0000001;
            4'd1:    seg_o = 7'b1001111;
            4'd2:    seg_o = 7'b0010010;
            4'd3:    seg_o = 7'b0000110;
            4'd4:    seg_o = 7'b1001100;
            4'd5:    seg_o = 7'b0100100;
            4'd6:    seg_o = 7'b0100000;
            4'd7:    seg_o = 7'b0001111;
            4'd8:    seg_o = 7'b0000000;
            4'd9:    seg_o = 7'b0000100;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Shares one 4-digit multiplexed 7-segment display between NUM_REQ clients:
// urgent client 0 preempts, others rotate after a minimum hold; owns digit scanning.
module seg_display_arbiter
    import seg_display_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int MIN_HOLD_CYC = 50000000,
    parameter int SCAN_CYC     = 131072,
    parameter int BLANK_CYC    = 2500
) (
    input  logic                    clock_50Mhz,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [16*NUM_REQ-1:0]   value_flat,
    output logic [NUM_REQ-1:0]      grant,
    output logic [1:0]              active_id,
    output logic [3:0]              an,
    output logic [6:0]              seg
);

    localparam int HOLD_W = $clog2(MIN_HOLD_CYC + 1);
    localparam int SCAN_W = $clog2(SCAN_CYC + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST   = HOLD_W'(MIN_HOLD_CYC - 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST   = SCAN_W'(SCAN_CYC - 1);
    localparam logic [SCAN_W-1:0]  BLANK_END   = SCAN_W'(BLANK_CYC);
    localparam logic [NUM_REQ-1:0] ONE_LSB     = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [NUM_REQ-1:0] GRANT_NONE  = {NUM_REQ{1'b0}};

    arb_state_e          state_q, state_d;
    logic [1:0]          target_q, target_d;
    logic [1:0]          rr_q, rr_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [1:0]          active_id_q, active_id_d;
    logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [1:0]          digit_q, digit_d;
    logic [3:0]          nib_q, nib_d;
    logic [3:0]          an_q, an_d;
    logic [6:0]          seg_q, seg_d;

    logic [NUM_REQ-1:0]  holder_mask_s;
    logic [NUM_REQ-1:0]  cand_s;
    logic                holder_req_s;
    logic                preempt_s;
    logic                hold_done_s;
    logic                active_s;
    logic                stay_s;
    logic                lit_s;
    logic [15:0]         client_val_s [4];
    logic [15:0]         holder_val_s;
    logic [3:0]          nib_live_s;
    logic [6:0]          dec_s;

    // First set candidate: client 0 wins outright, else scan 1..NUM_REQ-1 from ptr with wrap.
    function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] c, input logic [1:0] ptr);
        logic [1:0] pick;
        logic       found;
        int         idx;
        pick  = 2'd0;
        found = c[0];
        for (int k = 0; k < NUM_REQ - 1; k++) begin
            idx   = (int'(ptr) - 1 + k) % (NUM_REQ - 1) + 1;
            pick  = (!found && c[idx[1:0]]) ? idx[1:0] : pick;
            found = found | c[idx[1:0]];
        end
        return pick;
    endfunction

    function automatic logic [1:0] rr_after(input logic [1:0] t);
        logic [1:0] nxt;
        if (int'(t) + 1 >= NUM_REQ) begin
            nxt = 2'd1;
        end else begin
            nxt = t + 2'd1;
        end
        return nxt;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_client_val
        if (g < NUM_REQ) begin : g_used
            assign client_val_s[g] = value_flat[16*g +: 16];
        end else begin : g_unused
            assign client_val_s[g] = 16'h0000;
        end
    end

    assign holder_mask_s = ONE_LSB << active_id_q;
    assign cand_s        = req & ~holder_mask_s;
    assign holder_req_s  = req[active_id_q];
    assign preempt_s     = req[0] && (active_id_q != 2'd0);
    assign hold_done_s   = (hold_cnt_q == HOLD_LAST);
    assign holder_val_s  = client_val_s[active_id_q];

    // Arbiter next-state: grant and holder change only through the one-cycle SWITCH state.
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        rr_d        = rr_q;
        hold_cnt_d  = hold_cnt_q;
        grant_d     = grant_q;
        active_id_d = active_id_q;
        case (state_q)
            ST_IDLE: begin
                grant_d = GRANT_NONE;
                if (|req) begin
                    state_d  = ST_SWITCH;
                    target_d = rr_pick(req, rr_q);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!holder_req_s || preempt_s || (hold_done_s && (|cand_s))) begin
                    grant_d = GRANT_NONE;
                    if (|cand_s) begin
                        state_d  = ST_SWITCH;
                        target_d = rr_pick(cand_s, rr_q);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (hold_done_s) begin
                    state_d = ST_OPEN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_OPEN: begin
                if (|cand_s) begin
                    grant_d  = GRANT_NONE;
                    state_d  = ST_SWITCH;
                    target_d = rr_pick(cand_s, rr_q);
                end else if (!holder_req_s) begin
                    grant_d = GRANT_NONE;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OPEN;
                end
            end
            ST_SWITCH: begin
                // Target is granted even if its request dropped meanwhile; HOLD releases it.
                state_d     = ST_HOLD;
                grant_d     = ONE_LSB << target_q;
                active_id_d = target_q;
                hold_cnt_d  = {HOLD_W{1'b0}};
                rr_d        = rr_after(target_q);
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = GRANT_NONE;
            end
        endcase
    end

    assign active_s = (state_q == ST_HOLD) || (state_q == ST_OPEN);
    assign stay_s   = (state_d == ST_HOLD) || (state_d == ST_OPEN);
    assign lit_s    = active_s && stay_s && (scan_cnt_q >= BLANK_END);

    // Slot nibble of the holder; thousands sit in the top nibble.
    always_comb begin
        case (digit_q)
            2'd0:    nib_live_s = holder_val_s[15:12];
            2'd1:    nib_live_s = holder_val_s[11:8];
            2'd2:    nib_live_s = holder_val_s[7:4];
            2'd3:    nib_live_s = holder_val_s[3:0];
            default: nib_live_s = 4'h0;
        endcase
    end

    // Scan counters run only while someone holds the display, restarting at digit 0 after SWITCH.
    always_comb begin
        if (active_s) begin
            if (scan_cnt_q == SCAN_LAST) begin
                scan_cnt_d = {SCAN_W{1'b0}};
                digit_d    = digit_q + 2'd1;
            end else begin
                scan_cnt_d = scan_cnt_q + SCAN_W'(1);
                digit_d    = digit_q;
            end
        end else begin
            scan_cnt_d = {SCAN_W{1'b0}};
            digit_d    = 2'd0;
        end
        if (scan_cnt_q == {SCAN_W{1'b0}}) begin
            nib_d = nib_live_s;
        end else begin
            nib_d = nib_q;
        end
        if (lit_s) begin
            an_d  = digit_onehot(digit_q);
            seg_d = dec_s;
        end else begin
            an_d  = AN_OFF;
            seg_d = SEG_BLANK;
        end
    end

    bcd_to_seg7 u_dec (
        .bcd_i (nib_d),
        .seg_o (dec_s)
    );

    // Arbiter state and grant outputs.
    always_ff @(posedge clock_50Mhz or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            target_q    <= 2'd0;
            rr_q        <= 2'd1;
            hold_cnt_q  <= {HOLD_W{1'b0}};
            grant_q     <= GRANT_NONE;
            active_id_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            rr_q        <= rr_d;
            hold_cnt_q  <= hold_cnt_d;
            grant_q     <= grant_d;
            active_id_q <= active_id_d;
        end
    end

    // Scan position, sampled nibble and registered display drive.
    always_ff @(posedge clock_50Mhz or negedge reset) begin
        if (!reset) begin
            scan_cnt_q <= {SCAN_W{1'b0}};
            digit_q    <= 2'd0;
            nib_q      <= 4'h0;
            an_q       <= AN_OFF;
            seg_q      <= SEG_BLANK;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            digit_q    <= digit_d;
            nib_q      <= nib_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign grant     = grant_q;
    assign active_id = active_id_q;
    assign an        = an_q;
    assign seg       = seg_q;

endmodule
